// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage in-order core.
//               Arbitrates memory wait, taken-branch redirect, multi-cycle
//               divide wait (with watchdog) and load-use bubbles into
//               per-stage stall/flush controls, and keeps two performance
//               counters (stalled cycles, branch redirects).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_use_stall_i,
    input  logic                branch_taken_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    input  logic                div_start_i,
    input  logic                div_done_i,
    input  logic                mem_req_i,
    input  logic                mem_ready_i,
    output logic [4:0]          stall_o,
    output logic [3:0]          flush_o,
    output logic                redirect_valid_o,
    output logic [PC_WIDTH-1:0] redirect_pc_o,
    output logic                div_timeout_o,
    output logic [31:0]         stall_cycles_o,
    output logic [31:0]         flush_count_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Divide wait counter is wide enough to hold DIV_TIMEOUT-1.
    localparam int c_CNT_W = $clog2(DIV_TIMEOUT + 1);

    // Watchdog trips on the DIV_WAIT cycle whose increment would reach this.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV_TIMEOUT - 1);

    // Stall pattern: freeze PC..EXE/MEM, let MEM/WB drain (bubble it).
    localparam logic [4:0] c_STALL_FRONT = 5'b01111;
    localparam logic [3:0] c_FLUSH_WB    = 4'b1000;

    // Load-use: hold PC and IF/ID, insert a bubble into ID/EXE.
    localparam logic [4:0] c_STALL_LU    = 5'b00011;
    localparam logic [3:0] c_FLUSH_LU    = 4'b0010;

    // Taken branch: squash the two younger instructions.
    localparam logic [3:0] c_FLUSH_BR    = 4'b0011;

    localparam logic [31:0] c_CNT_MAX    = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_BUBBLE   = 2'd1,
        S_DIV_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_div_cnt;
    logic                 r_div_timeout;
    logic [31:0]          r_stall_cycles;
    logic [31:0]          r_flush_count;

    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   w_div_cnt_nxt;
    logic [c_CNT_W-1:0]   w_div_cnt_inc;
    logic                 w_timeout_set;
    logic                 w_mem_wait;
    logic [4:0]           w_stall;
    logic [3:0]           w_flush;
    logic                 w_redirect;

    // A data access that has not completed blocks everything, in any state.
    assign w_mem_wait    = mem_req_i & ~mem_ready_i;
    assign w_div_cnt_inc = r_div_cnt + 1'b1;

    // Next-state and output decode; priority is mem wait, branch, divide,
    // load-use. Outputs are forced quiet while reset is held.
    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_timeout_set = 1'b0;
        w_stall       = 5'b00000;
        w_flush       = 4'b0000;
        w_redirect    = 1'b0;

        if (w_mem_wait) begin
            // State and watchdog counter stay frozen while memory is busy.
            w_stall = c_STALL_FRONT;
            w_flush = c_FLUSH_WB;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (branch_taken_i) begin
                        w_flush    = c_FLUSH_BR;
                        w_redirect = 1'b1;
                    end else if (div_start_i) begin
                        w_stall       = c_STALL_FRONT;
                        w_flush       = c_FLUSH_WB;
                        w_state_nxt   = S_DIV_WAIT;
                        w_div_cnt_nxt = '0;
                    end else if (load_use_stall_i) begin
                        w_stall     = c_STALL_LU;
                        w_flush     = c_FLUSH_LU;
                        w_state_nxt = S_BUBBLE;
                    end
                end

                S_BUBBLE: begin
                    // The bubble is already in flight, so a repeated
                    // load-use flag for the same instruction is ignored.
                    w_state_nxt = S_RUN;
                    if (branch_taken_i) begin
                        w_flush    = c_FLUSH_BR;
                        w_redirect = 1'b1;
                    end else if (div_start_i) begin
                        w_stall       = c_STALL_FRONT;
                        w_flush       = c_FLUSH_WB;
                        w_state_nxt   = S_DIV_WAIT;
                        w_div_cnt_nxt = '0;
                    end
                end

                S_DIV_WAIT: begin
                    // Divide bookkeeping always advances; a taken branch only
                    // overrides what the pipeline sees this cycle.
                    if (div_done_i) begin
                        w_state_nxt = S_RUN;
                    end else if (w_div_cnt_inc == c_CNT_LAST) begin
                        // Watchdog: give up on the divider, release next cycle.
                        w_stall       = c_STALL_FRONT;
                        w_flush       = c_FLUSH_WB;
                        w_timeout_set = 1'b1;
                        w_div_cnt_nxt = w_div_cnt_inc;
                        w_state_nxt   = S_RUN;
                    end else begin
                        w_stall       = c_STALL_FRONT;
                        w_flush       = c_FLUSH_WB;
                        w_div_cnt_nxt = w_div_cnt_inc;
                    end
                    if (branch_taken_i) begin
                        w_stall    = 5'b00000;
                        w_flush    = c_FLUSH_BR;
                        w_redirect = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end

        if (!rst_n) begin
            w_stall    = 5'b00000;
            w_flush    = 4'b0000;
            w_redirect = 1'b0;
        end
    end

    // FSM state, divide watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_div_cnt     <= '0;
            r_div_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_div_cnt     <= w_div_cnt_nxt;
            r_div_timeout <= r_div_timeout | w_timeout_set;
        end
    end

    // Saturating performance counters: stalled-PC cycles and redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (w_stall[0] && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_redirect && (r_flush_count != c_CNT_MAX)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stall_o          = w_stall;
    assign flush_o          = w_flush;
    assign redirect_valid_o = w_redirect;
    assign redirect_pc_o    = w_redirect ? branch_target_i : '0;
    assign div_timeout_o    = r_div_timeout;
    assign stall_cycles_o   = r_stall_cycles;
    assign flush_count_o    = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A table of directed
//               vectors exercises the combinational priority decode, then
//               hand-written sequences cover divide wait, watchdog, memory
//               freeze and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lu;
    logic        br;
    logic [31:0] tgt;
    logic        ds;
    logic        dd;
    logic        mr;
    logic        mrdy;

    // Default-parameter instance
    logic [4:0]  stall;
    logic [3:0]  flush;
    logic        rv;
    logic [31:0] rpc;
    logic        to;
    logic [31:0] scyc;
    logic [31:0] fcnt;

    // Short-watchdog instance (DIV_TIMEOUT = 8)
    logic [4:0]  t_stall;
    logic [3:0]  t_flush;
    logic        t_rv;
    logic [31:0] t_rpc;
    logic        t_to;
    logic [31:0] t_scyc;
    logic [31:0] t_fcnt;

    int n_pass;
    int n_tot;

    hazard_ctrl #(.PC_WIDTH(32), .DIV_TIMEOUT(64)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_stall_i (lu),
        .branch_taken_i   (br),
        .branch_target_i  (tgt),
        .div_start_i      (ds),
        .div_done_i       (dd),
        .mem_req_i        (mr),
        .mem_ready_i      (mrdy),
        .stall_o          (stall),
        .flush_o          (flush),
        .redirect_valid_o (rv),
        .redirect_pc_o    (rpc),
        .div_timeout_o    (to),
        .stall_cycles_o   (scyc),
        .flush_count_o    (fcnt)
    );

    hazard_ctrl #(.PC_WIDTH(32), .DIV_TIMEOUT(8)) u_dut_to (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_stall_i (lu),
        .branch_taken_i   (br),
        .branch_target_i  (tgt),
        .div_start_i      (ds),
        .div_done_i       (dd),
        .mem_req_i        (mr),
        .mem_ready_i      (mrdy),
        .stall_o          (t_stall),
        .flush_o          (t_flush),
        .redirect_valid_o (t_rv),
        .redirect_pc_o    (t_rpc),
        .div_timeout_o    (t_to),
        .stall_cycles_o   (t_scyc),
        .flush_count_o    (t_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        lu;
        logic        br;
        logic [31:0] tgt;
        logic        ds;
        logic        dd;
        logic        mr;
        logic        mrdy;
        logic [4:0]  e_stall;
        logic [3:0]  e_flush;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rn, input logic l, input logic b,
                                input logic [31:0] t, input logic s,
                                input logic d, input logic m, input logic my,
                                input logic [4:0] es, input logic [3:0] ef,
                                input logic erv, input logic [31:0] epc);
        vec_t v;
        v.rn = rn; v.lu = l; v.br = b; v.tgt = t; v.ds = s; v.dd = d;
        v.mr = m; v.mrdy = my; v.e_stall = es; v.e_flush = ef;
        v.e_rv = erv; v.e_rpc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs on the falling edge, settle, then return.
    task automatic apply(input logic rn, input logic l, input logic b,
                         input logic [31:0] t, input logic s, input logic d,
                         input logic m, input logic my);
        @(negedge clk);
        rst_n = rn; lu = l; br = b; tgt = t; ds = s; dd = d; mr = m; mrdy = my;
        #1;
    endtask

    task automatic idle();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_sc;
        int exp_fc;
        n_pass = 0;
        n_tot  = 0;
        rst_n = 1'b0; lu = 1'b0; br = 1'b0; tgt = 32'h0;
        ds = 1'b0; dd = 1'b0; mr = 1'b0; mrdy = 1'b0;

        //               rn   lu   br   tgt           ds   dd   mr   mrdy  stall     flush    rv   rpc
        vecs[0]  = mk(1'b0,1'b1,1'b1,32'h0000_0100,1'b0,1'b0,1'b1,1'b0, 5'b00000,4'b0000,1'b0,32'h0);
        vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0000,1'b0,32'h0);
        vecs[2]  = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0, 5'b00011,4'b0010,1'b0,32'h0);
        vecs[3]  = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0000,1'b0,32'h0);
        vecs[4]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0000,1'b0,32'h0);
        vecs[5]  = mk(1'b1,1'b1,1'b1,32'h0000_0100,1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0011,1'b1,32'h0000_0100);
        vecs[6]  = mk(1'b1,1'b0,1'b1,32'hDEAD_BEEF,1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0011,1'b1,32'hDEAD_BEEF);
        vecs[7]  = mk(1'b1,1'b0,1'b1,32'h0000_0055,1'b0,1'b0,1'b1,1'b0, 5'b01111,4'b1000,1'b0,32'h0);
        vecs[8]  = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1, 5'b00011,4'b0010,1'b0,32'h0);
        vecs[9]  = mk(1'b1,1'b0,1'b1,32'h0000_0040,1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0011,1'b1,32'h0000_0040);
        vecs[10] = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0, 5'b01111,4'b1000,1'b0,32'h0);
        vecs[11] = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0, 5'b00011,4'b0010,1'b0,32'h0);
        vecs[12] = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0000,1'b0,32'h0);
        vecs[13] = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0, 5'b00000,4'b0000,1'b0,32'h0);

        // ---------------- table-driven decode ----------------
        exp_sc = 0;
        exp_fc = 0;
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rn, vecs[i].lu, vecs[i].br, vecs[i].tgt,
                  vecs[i].ds, vecs[i].dd, vecs[i].mr, vecs[i].mrdy);
            chk($sformatf("row%0d stall", i), 64'(stall), 64'(vecs[i].e_stall));
            chk($sformatf("row%0d flush", i), 64'(flush), 64'(vecs[i].e_flush));
            chk($sformatf("row%0d redirect_valid", i), 64'(rv), 64'(vecs[i].e_rv));
            chk($sformatf("row%0d redirect_pc", i), 64'(rpc), 64'(vecs[i].e_rpc));
            if (vecs[i].rn && vecs[i].e_stall[0]) exp_sc++;
            if (vecs[i].rn && vecs[i].e_rv) exp_fc++;
        end
        idle();
        chk("table stall_cycles", 64'(scyc), 64'(exp_sc));
        chk("table flush_count", 64'(fcnt), 64'(exp_fc));
        chk("table div_timeout", 64'(to), 64'd0);

        // ---------------- load-use held two cycles ----------------
        do_reset();
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu2 reset stall_cycles", 64'(scyc), 64'd0);
        chk("lu2 reset flush_count", 64'(fcnt), 64'd0);
        chk("lu2 c1 stall", 64'(stall), 64'b00011);
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu2 c2 stall", 64'(stall), 64'd0);
        idle();
        chk("lu2 stall_cycles", 64'(scyc), 64'd1);

        // ---------------- branch beats load-use ----------------
        do_reset();
        apply(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br flush", 64'(flush), 64'b0011);
        chk("br stall", 64'(stall), 64'd0);
        chk("br redirect_pc", 64'(rpc), 64'h100);
        idle();
        chk("br flush_count", 64'(fcnt), 64'd1);
        chk("br redirect_pc idle", 64'(rpc), 64'd0);

        // ---------------- divide completes after 10 cycles ----------------
        do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("div c0 stall", 64'(stall), 64'b01111);
        chk("div c0 flush", 64'(flush), 64'b1000);
        for (int k = 1; k < 10; k++) begin
            idle();
            chk($sformatf("div c%0d stall", k), 64'(stall), 64'b01111);
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("div done stall", 64'(stall), 64'd0);
        chk("div done flush", 64'(flush), 64'd0);
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("div after RUN lu stall", 64'(stall), 64'b00011);
        chk("div stall_cycles", 64'(scyc), 64'd10);
        chk("div timeout", 64'(to), 64'd0);

        // ---------------- watchdog with DIV_TIMEOUT=8 ----------------
        do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("wd c0 stall", 64'(t_stall), 64'b01111);
        for (int k = 1; k < 8; k++) begin
            idle();
            chk($sformatf("wd c%0d stall", k), 64'(t_stall), 64'b01111);
        end
        chk("wd c7 timeout", 64'(t_to), 64'd0);
        idle();
        chk("wd c8 stall released", 64'(t_stall), 64'd0);
        chk("wd c8 timeout", 64'(t_to), 64'd1);
        chk("wd stall_cycles", 64'(t_scyc), 64'd8);
        for (int k = 9; k < 12; k++) begin
            idle();
            chk($sformatf("wd c%0d sticky", k), 64'(t_to), 64'd1);
        end
        do_reset();
        idle();
        chk("wd timeout cleared", 64'(t_to), 64'd0);

        // ---------------- mem wait freezes DIV_WAIT (DIV_TIMEOUT=8) ----------------
        do_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        for (int k = 3; k < 6; k++) begin
            apply(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("mw c%0d stall", k), 64'(t_stall), 64'b01111);
            chk($sformatf("mw c%0d flush", k), 64'(t_flush), 64'b1000);
            chk($sformatf("mw c%0d redirect_valid", k), 64'(t_rv), 64'd0);
            chk($sformatf("mw c%0d redirect_pc", k), 64'(t_rpc), 64'd0);
        end
        for (int k = 6; k < 11; k++) begin
            idle();
            chk($sformatf("mw c%0d stall", k), 64'(t_stall), 64'b01111);
        end
        chk("mw c10 timeout", 64'(t_to), 64'd0);
        idle();
        chk("mw c11 stall released", 64'(t_stall), 64'd0);
        chk("mw c11 timeout", 64'(t_to), 64'd1);

        // ---------------- reset mid DIV_WAIT ----------------
        do_reset();
        apply(1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        chk("rst pre stall", 64'(stall), 64'b01111);
        apply(1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst flush", 64'(flush), 64'd0);
        chk("rst redirect_valid", 64'(rv), 64'd0);
        chk("rst redirect_pc", 64'(rpc), 64'd0);
        apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post rst lu stall", 64'(stall), 64'b00011);
        chk("post rst lu flush", 64'(flush), 64'b0010);
        chk("post rst stall_cycles", 64'(scyc), 64'd0);
        chk("post rst flush_count", 64'(fcnt), 64'd0);
        chk("post rst timeout", 64'(to), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
